// File: rtl/sym_fir_mac_engine.sv
// Symmetric FIR MAC engine: circular delay line, mirrored-tap pre-adder, TAPS/2 sequenced MACs, round/(optional) saturate.
// Latency: out_valid rises HALF+2 cycles after the accepting edge; one sample in flight at a time.
// Backpressure: in_ready/c_ready only in IDLE; dout/out_valid held stable in OUT until out_ready. Option macro: SYM_FIR_SAT_EN.
module sym_fir_mac_engine #(
    parameter int TAPS        = 86,
    parameter int SAMPLE_SIZE = 16,
    parameter int COEFF_SIZE  = 16,
    parameter int OUT_SHIFT   = 15
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [SAMPLE_SIZE-1:0]                     din,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [SAMPLE_SIZE-1:0]                     dout,
    input  logic                                       c_we,
    output logic                                       c_ready,
    input  logic [(((TAPS/2) > 1) ? $clog2(TAPS/2) : 1)-1:0] c_addr,
    input  logic [COEFF_SIZE-1:0]                      c_in,
    output logic                                       sat
);

    localparam int HALF   = TAPS / 2;
    localparam int CAW    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int PW     = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PRE_W  = SAMPLE_SIZE + 1;
    localparam int PROD_W = SAMPLE_SIZE + COEFF_SIZE + 1;
    localparam int ACC_W  = PROD_W + CAW;

    // Half-LSB of the output grid, added before the shift for round-half-up.
    localparam logic signed [ACC_W-1:0] RND = (OUT_SHIFT > 0) ? (ACC_W'(1) <<< (OUT_SHIFT - 1)) : '0;

`ifdef SYM_FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (SAMPLE_SIZE - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_ROUND,
        S_OUT
    } state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            ra_q, ra_d;          // walks backwards from the newest sample
    logic [PW-1:0]            rb_q, rb_d;          // walks forwards from the oldest sample
    logic [CAW-1:0]           k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic [SAMPLE_SIZE-1:0]   dout_q, dout_d;
    logic                     out_valid_q, out_valid_d;
`ifdef SYM_FIR_SAT_EN
    logic                     sat_q, sat_d;
`endif

    logic signed [SAMPLE_SIZE-1:0] dline_q [TAPS];
    logic signed [COEFF_SIZE-1:0]  coef_q  [HALF];

    logic                     dline_we;
    logic                     coef_we;
    logic [PW-1:0]            wr_nxt, ra_dec, rb_inc;
    logic                     k_last;
    logic signed [SAMPLE_SIZE-1:0] tap_a, tap_b;
    logic signed [COEFF_SIZE-1:0]  coef_k;
    logic signed [PRE_W-1:0]  pre_sum;
    logic signed [PROD_W-1:0] prod_mul;
    logic signed [ACC_W-1:0]  acc_prod, rnd_sum, rnd_val;

    // Datapath: modulo-TAPS pointer steps, pre-adder, multiplier and rounding shift.
    always_comb begin
        wr_nxt   = (wr_ptr_q == PW'(TAPS - 1)) ? '0 : wr_ptr_q + PW'(1);
        ra_dec   = (ra_q == '0) ? PW'(TAPS - 1) : ra_q - PW'(1);
        rb_inc   = (rb_q == PW'(TAPS - 1)) ? '0 : rb_q + PW'(1);
        k_last   = (k_q == CAW'(HALF - 1));
        tap_a    = dline_q[ra_q];
        tap_b    = dline_q[rb_q];
        coef_k   = coef_q[k_q];
        pre_sum  = PRE_W'(tap_a) + PRE_W'(tap_b);
        prod_mul = PROD_W'(pre_sum) * PROD_W'(coef_k);
        acc_prod = acc_q + ACC_W'(prod_q);
        rnd_sum  = acc_q + RND;
        rnd_val  = rnd_sum >>> OUT_SHIFT;
    end

    // Next-state and register-update logic for the IDLE/RUN/DRAIN/ROUND/OUT sequence.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        k_d         = k_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
`ifdef SYM_FIR_SAT_EN
        sat_d       = sat_q;
`endif
        dline_we    = 1'b0;
        coef_we     = c_we && (state_q == S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dline_we = 1'b1;
                    ra_d     = wr_ptr_q;
                    rb_d     = wr_nxt;
                    wr_ptr_d = wr_nxt;
                    acc_d    = '0;
                    prod_d   = '0;   // first RUN cycle accumulates nothing stale
                    k_d      = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                prod_d = prod_mul;
                acc_d  = acc_prod;
                ra_d   = ra_dec;
                rb_d   = rb_inc;
                if (k_last) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + CAW'(1);
                end
            end
            S_DRAIN: begin
                acc_d   = acc_prod;
                state_d = S_ROUND;
            end
            S_ROUND: begin
`ifdef SYM_FIR_SAT_EN
                if (rnd_val > SAT_MAX) begin
                    dout_d = SAMPLE_SIZE'(SAT_MAX);
                    sat_d  = 1'b1;
                end else if (rnd_val < SAT_MIN) begin
                    dout_d = SAMPLE_SIZE'(SAT_MIN);
                    sat_d  = 1'b1;
                end else begin
                    dout_d = SAMPLE_SIZE'(rnd_val);
                    sat_d  = 1'b0;
                end
`else
                dout_d = SAMPLE_SIZE'(rnd_val);
`endif
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
`ifdef SYM_FIR_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
`ifdef SYM_FIR_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    // Circular delay line; cleared by reset so an aborted sample leaves no history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                dline_q[i] <= '0;
            end
        end else if (dline_we) begin
            dline_q[wr_ptr_q] <= din;
        end
    end

    // Coefficient table: writable only while idle and deliberately kept across reset.
    always_ff @(posedge clk) begin
        if (coef_we) begin
            coef_q[c_addr] <= c_in;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign c_ready   = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign dout      = dout_q;
`ifdef SYM_FIR_SAT_EN
    assign sat       = sat_q;
`else
    assign sat       = 1'b0;
`endif

endmodule

// File: tb/tb_sym_fir_mac_engine.sv
// Bench for sym_fir_mac_engine with TAPS=8: directed vectors, expected outputs queued at issue time.
// A negedge monitor pops and compares on every out_valid&out_ready transfer.
// Covers reset state, impulse response, latency, backpressure, busy coef write, mid-run reset and overflow.
module tb_sym_fir_mac_engine;

    localparam int TAPS = 8;
    localparam int SS   = 16;
    localparam int CS   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SS-1:0] din = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SS-1:0] dout;
    logic          c_we = 1'b0;
    logic          c_ready;
    logic [1:0]    c_addr = '0;
    logic [CS-1:0] c_in = '0;
    logic          sat;

    int n_vec = 0;
    int n_err = 0;

    logic [SS-1:0] exp_d_q [$];
    logic          exp_s_q [$];

    // Impulse response of 0x4000 through coefficients 0x1000..0x4000 (h = c0 c1 c2 c3 c3 c2 c1 c0).
    logic [SS-1:0] t1 [9] = '{16'h0800, 16'h1000, 16'h1800, 16'h2000, 16'h2000,
                              16'h1800, 16'h1000, 16'h0800, 16'h0000};
    // Step of 0x7FFF through all-0x4000 coefficients: n-th output = floor((n*32767+1)/2).
`ifdef SYM_FIR_SAT_EN
    logic [SS-1:0] t3d [8] = '{16'h4000, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                               16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    logic          t3s [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`else
    logic [SS-1:0] t3d [8] = '{16'h4000, 16'h7FFF, 16'hBFFF, 16'hFFFE,
                               16'h3FFE, 16'h7FFD, 16'hBFFD, 16'hFFFC};
    logic          t3s [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    sym_fir_mac_engine #(
        .TAPS        (TAPS),
        .SAMPLE_SIZE (SS),
        .COEFF_SIZE  (CS),
        .OUT_SHIFT   (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .c_we      (c_we),
        .c_ready   (c_ready),
        .c_addr    (c_addr),
        .c_in      (c_in),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one pop per output transfer.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_d_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got dout 0x%0h with nothing expected at %0t", dout, $time);
            end else begin
                logic [SS-1:0] ed;
                logic          es;
                ed = exp_d_q.pop_front();
                es = exp_s_q.pop_front();
                chk("dout", 32'(dout), 32'(ed));
                chk("sat", 32'(sat), 32'(es));
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        c_we     = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic load_coef(input int a, input logic [CS-1:0] v);
        logic rdy;
        int   guard;
        c_we   = 1'b1;
        c_addr = 2'(a);
        c_in   = v;
        rdy    = 1'b0;
        guard  = 0;
        while (!rdy && guard < 300) begin
            @(negedge clk);
            rdy = c_ready;
            @(posedge clk);
            guard++;
        end
        if (!rdy) chk("coef_write_timeout", 32'(c_ready), 32'd1);
        #1;
        c_we = 1'b0;
    endtask

    task automatic send(input logic [SS-1:0] d, input bit push, input logic [SS-1:0] ed, input logic es);
        logic rdy;
        int   guard;
        in_valid = 1'b1;
        din      = d;
        rdy      = 1'b0;
        guard    = 0;
        while (!rdy && guard < 300) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            guard++;
        end
        if (!rdy) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
        end else if (push) begin
            exp_d_q.push_back(ed);
            exp_s_q.push_back(es);
        end
        #1;
        in_valid = 1'b0;
        din      = '0;
    endtask

    task automatic drain(input string nm);
        int guard;
        guard = 0;
        while ((exp_d_q.size() != 0 || !in_ready) && guard < 200) begin
            tick();
            guard++;
        end
        chk(nm, 32'(exp_d_q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // Reset state.
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_c_ready", 32'(c_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Impulse response with latency measurement on the first sample.
        for (int i = 0; i < 4; i++) load_coef(i, CS'((i + 1) * 16'h1000));
        out_ready = 1'b1;
        send(16'h4000, 1'b1, t1[0], 1'b0);
        lat = 0;
        while (lat < 50) begin
            tick();
            lat++;
            if (out_valid) break;
        end
        chk("latency", 32'(lat), 32'd6);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("in_ready_back", 32'(in_ready), 32'd1);
        for (int i = 1; i < 9; i++) send(16'h0000, 1'b1, t1[i], 1'b0);
        drain("drain_impulse");

        // Coefficient write while busy is dropped.
        send(16'h4000, 1'b1, t1[0], 1'b0);
        c_we   = 1'b1;
        c_addr = 2'd0;
        c_in   = 16'h7FFF;
        @(negedge clk);
        chk("c_ready_busy", 32'(c_ready), 32'd0);
        @(posedge clk);
        #1;
        c_we = 1'b0;
        for (int i = 1; i < 9; i++) send(16'h0000, 1'b1, t1[i], 1'b0);
        drain("drain_busy_coef");

        // Reset in the middle of RUN aborts the sample and clears history.
        send(16'h4000, 1'b0, 16'h0000, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_output", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("abort_dout", 32'(dout), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 9; i++) send((i == 0) ? 16'h4000 : 16'h0000, 1'b1, t1[i], 1'b0);
        drain("drain_after_abort");

        // Backpressure: output held, held input not taken; then 0x1234 gives 0x1247 (round half up).
        out_ready = 1'b0;
        send(16'h4000, 1'b1, 16'h0800, 1'b0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("bp_out_valid_rise", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        din      = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_dout", 32'(dout), 32'h0800);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(16'h1234, 1'b1, 16'h1247, 1'b0);
        drain("drain_backpressure");

        // Overflow: all-0x4000 coefficients, 0x7FFF step.
        do_reset();
        @(negedge clk);
        chk("rst2_sat", 32'(sat), 32'd0);
        for (int i = 0; i < 4; i++) load_coef(i, 16'h4000);
        for (int i = 0; i < 8; i++) send(16'h7FFF, 1'b1, t3d[i], t3s[i]);
        drain("drain_overflow");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
